// File: rtl/mc_rsp_model.sv
// mc_rsp_model: memory-controller responder stand-in for unit-level simulation
// and FPGA loopback. 64-bit word RAM, load queue, fixed-latency response pipe.
module mc_rsp_model #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4,
  parameter int QDEPTH    = 16,
  parameter int AFULL     = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mc_req_ld,
  input  logic                 mc_req_st,
  input  logic [47:0]          mc_req_vadr,
  input  logic [1:0]           mc_req_size,
  input  logic                 mc_req_flush,
  input  logic [63:0]          mc_req_wrd_rdctl,
  output logic                 mc_rd_rq_stall,
  output logic                 mc_wr_rq_stall,
  output logic                 mc_rsp_push,
  output logic [31:0]          mc_rsp_rdctl,
  output logic [63:0]          mc_rsp_data,
  input  logic                 mc_rsp_stall,
  input  logic [1:0]           stall_inj,
  input  logic                 init_we,
  input  logic [ADDR_BITS-1:0] init_addr,
  input  logic [63:0]          init_data,
  output logic [31:0]          ld_cnt,
  output logic [31:0]          st_cnt,
  output logic [3:0]           err
);

  localparam int PW    = $clog2(QDEPTH);
  localparam int CW    = PW + 1;
  localparam int WORDS = 2 ** ADDR_BITS;

  logic [63:0]          mem_q [WORDS];
  logic [31:0]          qrd_q [QDEPTH];
  logic [ADDR_BITS-1:0] qix_q [QDEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 rsp_stall_q, rd_stall_q, wr_stall_q;
  logic [31:0]          ld_cnt_q, st_cnt_q;
  logic [3:0]           err_q, err_d;
  logic                 rd_vld_q;
  logic [63:0]          rd_data_q;
  logic [31:0]          rd_rdctl_q;
  logic                 pv_q [LATENCY];
  logic [63:0]          pd_q [LATENCY];
  logic [31:0]          pr_q [LATENCY];

  logic [ADDR_BITS-1:0] req_idx;
  logic                 q_full, q_empty, ld_acc, st_acc, pop, bad_req, any_req;
  logic                 unused_vadr;

  assign unused_vadr = ^mc_req_vadr[47:ADDR_BITS+3];

  // Request decode, queue occupancy and sticky error accumulation
  always_comb begin
    req_idx = mc_req_vadr[ADDR_BITS+2:3];
    any_req = mc_req_ld | mc_req_st;
    q_full  = (count_q == CW'(QDEPTH));
    q_empty = (count_q == '0);
    ld_acc  = mc_req_ld & ~q_full;
    // A simultaneous load takes priority; the store is discarded.
    st_acc  = mc_req_st & ~mc_req_ld;
    pop     = ~q_empty & ~rsp_stall_q;
    count_d = count_q + CW'(ld_acc) - CW'(pop);
    bad_req = any_req & ((mc_req_size != 2'h3) | (mc_req_vadr[2:0] != 3'b000));
    err_d   = err_q | {any_req & mc_req_flush, mc_req_ld & q_full, bad_req,
                       mc_req_ld & mc_req_st};
  end

  // Queue pointers, stalls, counters and error flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_stall_q <= 1'b0;
      rd_stall_q  <= stall_inj[0];
      wr_stall_q  <= stall_inj[1];
      ld_cnt_q    <= '0;
      st_cnt_q    <= '0;
      err_q       <= '0;
    end else begin
      if (ld_acc) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q     <= count_d;
      rsp_stall_q <= mc_rsp_stall;
      rd_stall_q  <= (count_q >= CW'(AFULL)) | stall_inj[0];
      wr_stall_q  <= stall_inj[1];
      if (ld_acc) ld_cnt_q <= ld_cnt_q + 32'd1;
      if (st_acc) st_cnt_q <= st_cnt_q + 32'd1;
      err_q       <= err_d;
    end
  end

  // Load queue storage: rdctl and word index of each accepted load
  always_ff @(posedge clk) begin
    if (reset_n && ld_acc) begin
      qrd_q[wr_ptr_q] <= mc_req_wrd_rdctl[31:0];
      qix_q[wr_ptr_q] <= req_idx;
    end
  end

  // Word RAM: backdoor first so a same-index store overrides it; kept over reset
  always_ff @(posedge clk) begin
    if (init_we) mem_q[init_addr] <= init_data;
    if (reset_n && st_acc) mem_q[req_idx] <= mc_req_wrd_rdctl;
  end

  // Registered RAM read followed by LATENCY delay stages; data only moves with
  // a valid so the final stage holds its last response while push is low
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_vld_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_rdctl_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pv_q[i] <= 1'b0;
        pd_q[i] <= '0;
        pr_q[i] <= '0;
      end
    end else begin
      rd_vld_q <= pop;
      if (pop) begin
        rd_data_q  <= mem_q[qix_q[rd_ptr_q]];
        rd_rdctl_q <= qrd_q[rd_ptr_q];
      end
      pv_q[0] <= rd_vld_q;
      if (rd_vld_q) begin
        pd_q[0] <= rd_data_q;
        pr_q[0] <= rd_rdctl_q;
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        if (pv_q[i-1]) begin
          pd_q[i] <= pd_q[i-1];
          pr_q[i] <= pr_q[i-1];
        end
      end
    end
  end

  assign mc_rd_rq_stall = rd_stall_q;
  assign mc_wr_rq_stall = wr_stall_q;
  assign mc_rsp_push    = pv_q[LATENCY-1];
  assign mc_rsp_data    = pd_q[LATENCY-1];
  assign mc_rsp_rdctl   = pr_q[LATENCY-1];
  assign ld_cnt         = ld_cnt_q;
  assign st_cnt         = st_cnt_q;
  assign err            = err_q;

endmodule

// File: tb/tb_mc_rsp_model.sv
// Bench for mc_rsp_model: directed scenarios plus a randomized phase, checked
// against a queue-based model of RAM contents and expected responses.
module tb_mc_rsp_model;
  localparam int AB  = 10;
  localparam int LAT = 4;
  localparam int QD  = 16;
  localparam int AF  = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mc_req_ld, mc_req_st, mc_req_flush;
  logic [47:0]   mc_req_vadr;
  logic [1:0]    mc_req_size;
  logic [63:0]   mc_req_wrd_rdctl;
  logic          mc_rd_rq_stall, mc_wr_rq_stall, mc_rsp_push;
  logic [31:0]   mc_rsp_rdctl;
  logic [63:0]   mc_rsp_data;
  logic          mc_rsp_stall;
  logic [1:0]    stall_inj;
  logic          init_we;
  logic [AB-1:0] init_addr;
  logic [63:0]   init_data;
  logic [31:0]   ld_cnt, st_cnt;
  logic [3:0]    err;

  mc_rsp_model #(.ADDR_BITS(AB), .LATENCY(LAT), .QDEPTH(QD), .AFULL(AF)) dut (
    .clk(clk), .reset_n(reset_n), .mc_req_ld(mc_req_ld), .mc_req_st(mc_req_st),
    .mc_req_vadr(mc_req_vadr), .mc_req_size(mc_req_size), .mc_req_flush(mc_req_flush),
    .mc_req_wrd_rdctl(mc_req_wrd_rdctl), .mc_rd_rq_stall(mc_rd_rq_stall),
    .mc_wr_rq_stall(mc_wr_rq_stall), .mc_rsp_push(mc_rsp_push),
    .mc_rsp_rdctl(mc_rsp_rdctl), .mc_rsp_data(mc_rsp_data), .mc_rsp_stall(mc_rsp_stall),
    .stall_inj(stall_inj), .init_we(init_we), .init_addr(init_addr),
    .init_data(init_data), .ld_cnt(ld_cnt), .st_cnt(st_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   rdctl;
    logic [63:0]   data;
    logic [AB-1:0] idx;
  } rsp_t;

  rsp_t        expq[$];
  logic [63:0] mem_m [2**AB];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          push_total = 0;
  int          push_cyc[$];
  logic [63:0] last_data;
  logic [31:0] exp_ld, exp_st;
  logic [3:0]  exp_err;
  bit          drop_nxt = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pending(input logic [AB-1:0] ix);
    foreach (expq[i]) if (expq[i].idx == ix) return 1'b1;
    return 1'b0;
  endfunction

  // Apply the model for the upcoming edge, advance one cycle, check responses.
  task automatic tick();
    logic [AB-1:0] idx;
    rsp_t e;
    idx = mc_req_vadr[AB+2:3];
    if (init_we) mem_m[init_addr] = init_data;
    if (!reset_n) begin
      expq.delete();
      exp_ld = '0; exp_st = '0; exp_err = '0;
    end else begin
      if (mc_req_ld) begin
        if (drop_nxt) exp_err[2] = 1'b1;
        else begin
          e.rdctl = mc_req_wrd_rdctl[31:0];
          e.data  = mem_m[idx];
          e.idx   = idx;
          expq.push_back(e);
          exp_ld = exp_ld + 32'd1;
        end
        if (mc_req_st) exp_err[0] = 1'b1;
      end else if (mc_req_st) begin
        mem_m[idx] = mc_req_wrd_rdctl;
        exp_st = exp_st + 32'd1;
      end
      if ((mc_req_ld || mc_req_st) && (mc_req_size != 2'h3 || mc_req_vadr[2:0] != 3'b0))
        exp_err[1] = 1'b1;
      if ((mc_req_ld || mc_req_st) && mc_req_flush) exp_err[3] = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mc_rsp_push) begin
      push_total++;
      push_cyc.push_back(cyc);
      last_data = mc_rsp_data;
      checks++;
      assert (expq.size() != 0) else begin
        failures++;
        $error("FAIL rsp_unexpected observed push=1 expected push=0");
      end
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("rsp_data", mc_rsp_data, e.data);
        chk("rsp_rdctl", {32'b0, mc_rsp_rdctl}, {32'b0, e.rdctl});
      end
    end
  endtask

  task automatic set_idle();
    mc_req_ld = 1'b0; mc_req_st = 1'b0; mc_req_flush = 1'b0;
    mc_req_vadr = '0; mc_req_size = 2'h3; mc_req_wrd_rdctl = '0;
    init_we = 1'b0; init_addr = '0; init_data = '0;
  endtask

  task automatic idle(input int n);
    set_idle();
    repeat (n) tick();
  endtask

  task automatic do_ld(input logic [47:0] va, input logic [31:0] rc);
    set_idle();
    mc_req_ld = 1'b1; mc_req_vadr = va; mc_req_wrd_rdctl = {32'h0, rc};
    tick();
  endtask

  task automatic do_st(input logic [47:0] va, input logic [63:0] d);
    set_idle();
    mc_req_st = 1'b1; mc_req_vadr = va; mc_req_wrd_rdctl = d;
    tick();
  endtask

  task automatic do_reset();
    set_idle();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    set_idle();
    mc_rsp_stall = 1'b0;
    while (expq.size() != 0 && n < 200) begin tick(); n++; end
    chk("drain_done", 64'(expq.size()), 64'd0);
    repeat (LAT + 3) tick();
  endtask

  initial begin
    int t0, p0;
    logic [AB-1:0] ix;
    reset_n = 1'b0; mc_rsp_stall = 1'b0; stall_inj = 2'b00;
    set_idle();
    do_reset();
    chk("rst_push", {63'b0, mc_rsp_push}, 64'd0);
    chk("rst_rdctl", {32'b0, mc_rsp_rdctl}, 64'd0);
    chk("rst_data", mc_rsp_data, 64'd0);
    chk("rst_ld_cnt", {32'b0, ld_cnt}, 64'd0);
    chk("rst_st_cnt", {32'b0, st_cnt}, 64'd0);
    chk("rst_err", {60'b0, err}, 64'd0);
    chk("rst_stalls", {62'b0, mc_rd_rq_stall, mc_wr_rq_stall}, 64'd0);

    for (int w = 0; w < 2**AB; w++) begin
      init_we = 1'b1; init_addr = AB'(w); init_data = {$urandom, $urandom};
      tick();
    end
    for (int w = 5; w < 8; w++) begin
      init_we = 1'b1; init_addr = AB'(w); init_data = 64'h11 * 64'(w - 4);
      tick();
    end
    idle(2);

    // Latency and back-to-back ordering from backdoor-written words
    push_cyc.delete();
    do_ld(48'h28, 32'd1); t0 = cyc;
    do_ld(48'h30, 32'd0);
    do_ld(48'h38, 32'd1);
    idle(LAT + 6);
    chk("lat_push_count", 64'(push_cyc.size()), 64'd3);
    chk("lat_first", 64'(push_cyc[0] - t0), 64'(LAT + 1));
    chk("lat_second", 64'(push_cyc[1] - t0), 64'(LAT + 2));
    chk("lat_third", 64'(push_cyc[2] - t0), 64'(LAT + 3));
    chk("lat_last_data", last_data, 64'h33);
    chk("ld_cnt_3", {32'b0, ld_cnt}, 64'd3);

    // Store then load on the very next cycle
    do_st(48'h100, 64'hDEADBEEF);
    do_ld(48'h100, 32'h77);
    drain();
    chk("st_ld_data", last_data, 64'hDEADBEEF);
    chk("st_cnt_1", {32'b0, st_cnt}, 64'd1);

    // Response stall: fill past AFULL, nothing pushes, then ordered release
    mc_rsp_stall = 1'b1;
    idle(2);
    p0 = push_total;
    for (int i = 0; i < 14; i++) begin
      do_ld({35'($urandom), 10'($urandom), 3'b0}, $urandom);
      if (i == 11) chk("rd_stall_below_afull", {63'b0, mc_rd_rq_stall}, 64'd0);
      if (i == 12) chk("rd_stall_at_afull", {63'b0, mc_rd_rq_stall}, 64'd1);
    end
    idle(LAT + 4);
    chk("rd_stall_held", {63'b0, mc_rd_rq_stall}, 64'd1);
    chk("stalled_no_push", 64'(push_total - p0), 64'd0);
    chk("stalled_err", {60'b0, err}, 64'd0);
    push_cyc.delete();
    drain();
    chk("release_count", 64'(push_cyc.size()), 64'd14);
    chk("release_span", 64'(push_cyc[13] - push_cyc[0]), 64'd13);
    chk("rd_stall_clear", {63'b0, mc_rd_rq_stall}, 64'd0);

    // Overfill: 17th load dropped
    do_reset();
    mc_rsp_stall = 1'b1;
    idle(2);
    for (int i = 0; i < 17; i++) begin
      drop_nxt = (i == 16);
      do_ld({35'h0, 10'(100 + i), 3'b0}, 32'(i));
    end
    drop_nxt = 1'b0;
    idle(1);
    chk("drop_err", {60'b0, err}, 64'h4);
    chk("drop_ld_cnt", {32'b0, ld_cnt}, 64'd16);
    push_cyc.delete();
    drain();
    chk("drop_rsp_count", 64'(push_cyc.size()), 64'd16);

    // Load and store together with bad size: load wins, store discarded
    do_reset();
    set_idle();
    mc_req_ld = 1'b1; mc_req_st = 1'b1; mc_req_size = 2'h2;
    mc_req_vadr = 48'h200; mc_req_wrd_rdctl = 64'h12345678_9ABCDEF0;
    tick();
    drain();
    chk("ldst_err", {60'b0, err}, 64'h3);
    chk("ldst_st_cnt", {32'b0, st_cnt}, 64'd0);
    do_ld(48'h200, 32'h5);
    drain();
    chk("ldst_not_written", last_data, mem_m[64]);
    chk("ldst_ld_cnt", {32'b0, ld_cnt}, 64'd2);

    // Store beats backdoor write to the same index; flush flag; stall injection
    set_idle();
    mc_req_st = 1'b1; mc_req_vadr = 48'h230; mc_req_wrd_rdctl = 64'hAAAA;
    mc_req_flush = 1'b1;
    init_we = 1'b1; init_addr = 10'd70; init_data = 64'hBBBB;
    tick();
    do_ld(48'h230, 32'h9);
    drain();
    chk("store_beats_init", last_data, 64'hAAAA);
    chk("flush_err", {60'b0, err}, {60'b0, exp_err});
    stall_inj = 2'b11;
    idle(1);
    chk("inj_stalls", {62'b0, mc_rd_rq_stall, mc_wr_rq_stall}, 64'd3);
    stall_inj = 2'b00;
    idle(1);
    chk("inj_stalls_off", {62'b0, mc_rd_rq_stall, mc_wr_rq_stall}, 64'd0);

    // Reset with loads in flight: no responses survive, RAM retained
    do_ld(48'h28, 32'h1);
    do_ld(48'h30, 32'h2);
    do_ld(48'h38, 32'h3);
    do_reset();
    p0 = push_total;
    idle(LAT + 6);
    chk("reset_no_push", 64'(push_total - p0), 64'd0);
    chk("reset_ld_cnt", {32'b0, ld_cnt}, 64'd0);
    chk("reset_st_cnt", {32'b0, st_cnt}, 64'd0);
    chk("reset_err", {60'b0, err}, 64'd0);
    do_ld(48'h30, 32'h4);
    drain();
    chk("reset_ram_kept", last_data, 64'h22);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int r;
      set_idle();
      mc_rsp_stall = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 7);
      ix = AB'($urandom);
      mc_req_vadr = {3'($urandom), 32'($urandom), ix, 3'b000};
      if ($urandom_range(0, 15) == 0) mc_req_vadr[2:0] = 3'($urandom);
      mc_req_size = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'h3;
      mc_req_wrd_rdctl = {$urandom, $urandom};
      if (r < 3 && !mc_rd_rq_stall) mc_req_ld = 1'b1;
      else if (r >= 3 && r <= 5 && !pending(ix)) mc_req_st = 1'b1;
      else if (r == 6 && !mc_rd_rq_stall) begin mc_req_ld = 1'b1; mc_req_st = 1'b1; end
      if ($urandom_range(0, 7) == 0) begin
        ix = AB'($urandom);
        if (!pending(ix)) begin
          init_we = 1'b1; init_addr = ix; init_data = {$urandom, $urandom};
        end
      end
      tick();
    end
    drain();
    chk("rand_ld_cnt", {32'b0, ld_cnt}, {32'b0, exp_ld});
    chk("rand_st_cnt", {32'b0, st_cnt}, {32'b0, exp_st});
    chk("rand_err", {60'b0, err}, {60'b0, exp_err});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
